mmio_rsp_stage: RTL and testbench
=================================

# mmio_rsp_stage

MMIO-facing queue and read-response stage for the AFU. Consumes decoded MMIO write/read requests from the CCI-P Rx c0 channel. Buffers 64-bit write payloads in an internal FIFO, pops on reads of the data address, exposes a status/clear register pair, and produces the registered Tx c2 read response (data plus echoed TID) for every MMIO read.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two, ≥2
- DATA_ADDR, 16'h0020: write pushes, read pops
- STAT_ADDR, 16'h0022: status read
- CLR_ADDR, 16'h0024: clear/flush write
- PEEK_ADDR, 16'h0026: non-destructive head read (only with the peek macro)

Ports:
- clk  in  1  sole clock
- rst  in  1  reset; synchronous, active-high
- wr_valid  in  1  MMIO write strobe (rx.c0.mmioWrValid)
- wr_addr  in  16  MMIO write address
- wr_data  in  64  MMIO write data, rx.c0.data[63:0]
- rd_valid  in  1  MMIO read strobe (rx.c0.mmioRdValid)
- rd_addr  in  16  MMIO read address
- rd_tid  in  9  read TID
- ext_data  in  64  parent's data for unowned addresses (DFH, AFU_ID); valid in the rd_valid cycle
- rsp_valid  out  1  drives tx.c2.mmioRdValid
- rsp_tid  out  9  drives tx.c2.hdr.tid
- rsp_data  out  64  drives tx.c2.data
- count  out  $clog2(DEPTH+1)  current occupancy
- full, empty  out  1 each  occupancy flags
- ovf, udf  out  1 each  sticky overflow/underflow

## Operation
- Write to DATA_ADDR:
  - not full: push wr_data at tail.
  - full: drop the write, set ovf, increment drop_cnt.
  - drop_cnt is 16 bits and saturates at 16'hFFFF.
- Write to CLR_ADDR:
  - wr_data[0]=1: clear ovf, udf, drop_cnt.
  - wr_data[1]=1: flush (head=tail, count=0; stored data is not zeroed).
  - Both bits set: both actions, same cycle.
- Writes to other addresses are ignored.
- Read of DATA_ADDR:
  - not empty: return the head entry and pop it.
  - empty: return 64'h0 and set udf.
- Read of STAT_ADDR returns {drop_cnt[15:0], 16'h0, zero-extended count in [31:16], 12'h0, udf, ovf, full, empty}. The status value reflects pre-update state in the rd_valid cycle.
- Reads of any other address return ext_data as sampled in the rd_valid cycle.
- Every rd_valid produces exactly one response. Reads are never dropped.
- Simultaneous wr_valid and rd_valid in one cycle are both honoured:
  - Pop decisions use pre-push state. Empty plus simultaneous push returns 0, sets udf, and the push lands.
  - Full plus simultaneous pop accepts the push; count is unchanged.
  - Flush plus simultaneous pop: the pop returns the old head, then the queue ends empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, range 0..DEPTH.

## Timing
- Reset values: rsp_valid=0, rsp_tid=0, rsp_data=0, count=0, empty=1, full=0, ovf=0, udf=0; drop_cnt=0, pointers=0.
- Response latency is exactly 1 cycle. rsp_* are registered on the edge after rd_valid.
- rsp_valid is a single-cycle pulse, cleared every cycle without a read.
- Back-to-back reads produce back-to-back responses; there is no backpressure.
- rsp_tid/rsp_data hold their last value when rsp_valid=0.
- count, full, empty, ovf and udf update on the edge following the causing request.
- Reset asserted mid-stream takes priority over everything: a read in the reset cycle gets no response, and queue contents are discarded.

## Configuration
- MMIO_RSP_STAGE_PEEK_EN defined: a read of PEEK_ADDR returns the head without popping. Empty returns 64'h0 with no udf.
- MMIO_RSP_STAGE_PEEK_EN undefined: PEEK_ADDR is unowned and returns ext_data.

## Structure
- Package mmio_rsp_pkg holds:
  - the default address constants;
  - the t_mmio_stat packed struct (status word layout);
  - the CLR bit positions;
  - the TID width constant.
- One sub-module, mmio_rsp_queue: the storage array, pointers, count and flags, with push/pop/flush inputs and a combinational head output.
- The top level holds address decode, stickies, drop_cnt and the response register.

## Test plan
- Reset, write 0xA, 0xB, 0xC to 0x0020, then read 0x0020 three times with TIDs 1, 2, 3 → responses 0xA, 0xB, 0xC one cycle after each read, with TIDs echoed; afterwards count=0, empty=1.
- DEPTH=8: nine writes, then read 0x0022 → full=1, ovf=1, drop_cnt=1, count field=8. Write 0x1 to 0x0024 → ovf=0, drop_cnt=0, data kept.
- Read 0x0020 when empty → rsp_data=0, udf=1. Same-cycle write 0x55 and read 0x0020 on empty → response 0, count=1; the next read returns 0x55.
- Fill to 8, then same-cycle write 0x99 plus read → returns the oldest entry, count stays 8, ovf=0. Drain the queue → 0x99 arrives last (pointer wrap checked).
- Read 0x0000 with ext_data=0x1000_0000_0000_0000, TID 0x1FF → that data and TID 0x1FF. Reset asserted during a read → no rsp_valid the next cycle, count=0.
- With MMIO_RSP_STAGE_PEEK_EN: after writing 0x7, reading 0x0026 twice returns 0x7 both times and count stays 1. Without the macro → returns ext_data.

Source files
------------

// File: rtl/mmio_rsp_pkg.sv
// -----------------------------------------------------------------------------
// mmio_rsp_pkg
// Shared constants and types for the MMIO response stage:
//   - default MMIO addresses owned by the stage (data, status, clear, peek)
//   - TID / data / drop-counter widths
//   - bit positions inside a write to the clear register
//   - t_mmio_stat: layout of the 64-bit status word, plus a packing helper
// -----------------------------------------------------------------------------
package mmio_rsp_pkg;

   localparam logic [15:0] DATA_ADDR_DEF = 16'h0020;
   localparam logic [15:0] STAT_ADDR_DEF = 16'h0022;
   localparam logic [15:0] CLR_ADDR_DEF  = 16'h0024;
   localparam logic [15:0] PEEK_ADDR_DEF = 16'h0026;

   localparam int TID_W  = 9;
   localparam int DATA_W = 64;
   localparam int DROP_W = 16;

   // Bits of the data word written to the clear register.
   localparam int CLR_STICKY_BIT = 0;  // clear ovf, udf and drop_cnt
   localparam int CLR_FLUSH_BIT  = 1;  // discard all queued entries

   // Status word, MSB first.
   typedef struct packed {
      logic [15:0] drop_cnt;
      logic [15:0] rsvd_hi;
      logic [15:0] count;
      logic [11:0] rsvd_lo;
      logic        udf;
      logic        ovf;
      logic        full;
      logic        empty;
   } t_mmio_stat;

   function automatic t_mmio_stat pack_stat(input logic [15:0] drop_cnt,
                                            input logic [15:0] count,
                                            input logic        udf,
                                            input logic        ovf,
                                            input logic        full,
                                            input logic        empty);
      t_mmio_stat s;
      s.drop_cnt = drop_cnt;
      s.rsvd_hi  = '0;
      s.count    = count;
      s.rsvd_lo  = '0;
      s.udf      = udf;
      s.ovf      = ovf;
      s.full     = full;
      s.empty    = empty;
      return s;
   endfunction

endpackage

// File: rtl/mmio_rsp_queue.sv
// -----------------------------------------------------------------------------
// mmio_rsp_queue
// Circular FIFO holding 64-bit MMIO write payloads.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   push           store push_data at the tail (caller guarantees room)
//   pop            advance the head (caller guarantees not empty)
//   flush          discard every entry; wins over a same-cycle push
//   push_data      payload to store
//   head           combinational view of the oldest entry
//   count          occupancy 0..DEPTH
//   full, empty    occupancy flags derived from count
// Pointers are log2(DEPTH) bits and wrap naturally; DEPTH must be a power of
// two so the wrap lands on entry 0.
// -----------------------------------------------------------------------------
module mmio_rsp_queue
   import mmio_rsp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [DATA_W-1:0]          push_data,
   output logic [DATA_W-1:0]          head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  head_ptr;
   logic [PTR_W-1:0]  tail_ptr;
   logic [PTR_W-1:0]  tail_nxt;

   assign tail_nxt = push ? tail_ptr + PTR_W'(1) : tail_ptr;

   // NOTE: the storage array is deliberately not reset; reset empties the
   // queue through the pointers and count, and stale data is never visible.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[tail_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         tail_ptr <= tail_nxt;
         if (flush) begin
            // Head catches up with the tail; entries stay in place but are
            // unreachable.
            head_ptr <= tail_nxt;
            count    <= '0;
         end else begin
            if (pop) begin
               head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   assign head  = mem[head_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/mmio_rsp_stage.sv
// -----------------------------------------------------------------------------
// mmio_rsp_stage
// MMIO-facing write queue and read-response stage for the AFU.
//   - write DATA_ADDR : push wr_data (dropped with ovf/drop_cnt when full)
//   - write CLR_ADDR  : bit0 clears ovf/udf/drop_cnt, bit1 flushes the queue
//   - read  DATA_ADDR : pop and return the head (0 and udf when empty)
//   - read  STAT_ADDR : status word (t_mmio_stat), pre-update state
//   - read  PEEK_ADDR : head without popping when MMIO_RSP_STAGE_PEEK_EN is
//                       defined, otherwise treated like any other address
//   - read  elsewhere : ext_data from the parent
// Every read gets exactly one registered response one cycle later.
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   wr_valid, wr_addr, wr_data    MMIO write request
//   rd_valid, rd_addr, rd_tid     MMIO read request
//   ext_data                      parent's read data for unowned addresses
//   rsp_valid, rsp_tid, rsp_data  read response (Tx c2)
//   count, full, empty            queue occupancy
//   ovf, udf                      sticky overflow / underflow
// Build option: MMIO_RSP_STAGE_PEEK_EN enables the peek register.
// -----------------------------------------------------------------------------
module mmio_rsp_stage
   import mmio_rsp_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter logic [15:0] DATA_ADDR = DATA_ADDR_DEF,
   parameter logic [15:0] STAT_ADDR = STAT_ADDR_DEF,
   parameter logic [15:0] CLR_ADDR  = CLR_ADDR_DEF,
   parameter logic [15:0] PEEK_ADDR = PEEK_ADDR_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   input  logic [15:0]                wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_valid,
   input  logic [15:0]                rd_addr,
   input  logic [TID_W-1:0]           rd_tid,
   input  logic [DATA_W-1:0]          ext_data,
   output logic                       rsp_valid,
   output logic [TID_W-1:0]           rsp_tid,
   output logic [DATA_W-1:0]          rsp_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf,
   output logic                       udf
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] q_head;
   logic [CNT_W-1:0]  q_count;
   logic              q_full;
   logic              q_empty;

   logic wr_data_hit;
   logic wr_clr_hit;
   logic rd_data_hit;
   logic rd_stat_hit;
   logic rd_peek_hit;

   logic push;
   logic pop;
   logic flush;
   logic drop;
   logic clr_sticky;
   logic udf_set;

   logic [DROP_W-1:0] drop_cnt;
   t_mmio_stat        stat;
   logic [DATA_W-1:0] rsp_data_nxt;

   // ---------------------------------------------------------------- decode
   assign wr_data_hit = wr_valid && (wr_addr == DATA_ADDR);
   assign wr_clr_hit  = wr_valid && (wr_addr == CLR_ADDR);
   assign rd_data_hit = rd_valid && (rd_addr == DATA_ADDR);
   assign rd_stat_hit = rd_valid && (rd_addr == STAT_ADDR);
   assign rd_peek_hit = rd_valid && (rd_addr == PEEK_ADDR);

   // Pop decisions look at pre-push state, so a read of an empty queue
   // underflows even when a push lands in the same cycle. A full queue still
   // accepts a push when a pop frees a slot in the same cycle.
   assign pop        = rd_data_hit && !q_empty;
   assign udf_set    = rd_data_hit &&  q_empty;
   assign push       = wr_data_hit && (!q_full || pop);
   assign drop       = wr_data_hit &&   q_full && !pop;
   assign flush      = wr_clr_hit  && wr_data[CLR_FLUSH_BIT];
   assign clr_sticky = wr_clr_hit  && wr_data[CLR_STICKY_BIT];

   mmio_rsp_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_data (wr_data),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign count = q_count;
   assign full  = q_full;
   assign empty = q_empty;

   // ------------------------------------------------ stickies and drop count
   // A same-cycle underflow beats a clear so the event is never lost.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf      <= 1'b0;
         udf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (drop) begin
            ovf <= 1'b1;
         end else if (clr_sticky) begin
            ovf <= 1'b0;
         end

         if (udf_set) begin
            udf <= 1'b1;
         end else if (clr_sticky) begin
            udf <= 1'b0;
         end

         if (drop) begin
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + DROP_W'(1);
            end
         end else if (clr_sticky) begin
            drop_cnt <= '0;
         end
      end
   end

   // ------------------------------------------------------- response select
   assign stat = pack_stat(drop_cnt, 16'(q_count), udf, ovf, q_full, q_empty);

   // NOTE: the default assignment first covers every path, so no latch is
   // inferred for rsp_data_nxt.
   always_comb begin
      rsp_data_nxt = ext_data;
      if (rd_data_hit) begin
         rsp_data_nxt = q_empty ? '0 : q_head;
      end else if (rd_stat_hit) begin
         rsp_data_nxt = stat;
      end else if (rd_peek_hit) begin
`ifdef MMIO_RSP_STAGE_PEEK_EN
         rsp_data_nxt = q_empty ? '0 : q_head;
`else
         rsp_data_nxt = ext_data;
`endif
      end
   end

   // ----------------------------------------------------- response register
   // rsp_valid pulses for one cycle per read; tid/data hold between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_tid   <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= rd_valid;
         if (rd_valid) begin
            rsp_tid  <= rd_tid;
            rsp_data <= rsp_data_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mmio_rsp_stage.sv
// -----------------------------------------------------------------------------
// tb_mmio_rsp_stage
// Directed, table-driven bench for mmio_rsp_stage (DEPTH=8, default addresses).
// Each table row is one clock cycle of requests plus the expected response and
// queue/sticky state one edge later. Reset behaviour is covered by hand-written
// sequences around the table. Honours MMIO_RSP_STAGE_PEEK_EN for peek rows.
// -----------------------------------------------------------------------------
module tb_mmio_rsp_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic [15:0] wr_addr;
   logic [63:0] wr_data;
   logic        rd_valid;
   logic [15:0] rd_addr;
   logic [8:0]  rd_tid;
   logic [63:0] ext_data;
   logic        rsp_valid;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;
   logic [3:0]  count;
   logic        full;
   logic        empty;
   logic        ovf;
   logic        udf;

   int total = 0;
   int bad   = 0;

`ifdef MMIO_RSP_STAGE_PEEK_EN
   localparam bit PEEK = 1'b1;
`else
   localparam bit PEEK = 1'b0;
`endif

   always #5 clk = ~clk;

   mmio_rsp_stage #(.DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_addr   (rd_addr),
      .rd_tid    (rd_tid),
      .ext_data  (ext_data),
      .rsp_valid (rsp_valid),
      .rsp_tid   (rsp_tid),
      .rsp_data  (rsp_data),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .ovf       (ovf),
      .udf       (udf)
   );

   typedef struct {
      logic        wv;
      logic [15:0] wa;
      logic [63:0] wd;
      logic        rv;
      logic [15:0] ra;
      logic [8:0]  tid;
      logic [63:0] ext;
      logic        ev;
      logic [63:0] ed;
      logic [3:0]  ecnt;
      logic        eovf;
      logic        eudf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                               input logic rv, input logic [15:0] ra, input logic [8:0] tid,
                               input logic [63:0] ext, input logic [63:0] ed,
                               input logic [3:0] ecnt, input logic eovf, input logic eudf);
      vec_t v;
      v.wv = wv; v.wa = wa; v.wd = wd;
      v.rv = rv; v.ra = ra; v.tid = tid; v.ext = ext;
      v.ev = rv; v.ed = ed;
      v.ecnt = ecnt; v.eovf = eovf; v.eudf = eudf;
      return v;
   endfunction

   // Shorthands: write only, read only, write+read in the same cycle.
   function automatic vec_t w(input logic [15:0] a, input logic [63:0] d,
                              input logic [3:0] c, input logic o, input logic u);
      return mk(1'b1, a, d, 1'b0, 16'h0, 9'h0, 64'h0, 64'h0, c, o, u);
   endfunction

   function automatic vec_t r(input logic [15:0] a, input logic [8:0] t, input logic [63:0] ext,
                              input logic [63:0] ed, input logic [3:0] c, input logic o,
                              input logic u);
      return mk(1'b0, 16'h0, 64'h0, 1'b1, a, t, ext, ed, c, o, u);
   endfunction

   function automatic vec_t wr(input logic [15:0] wa, input logic [63:0] wd,
                               input logic [15:0] ra, input logic [8:0] t,
                               input logic [63:0] ed, input logic [3:0] c, input logic o,
                               input logic u);
      return mk(1'b1, wa, wd, 1'b1, ra, t, 64'h0, ed, c, o, u);
   endfunction

   task automatic idle_inputs();
      wr_valid = 1'b0; wr_addr = 16'h0; wr_data = 64'h0;
      rd_valid = 1'b0; rd_addr = 16'h0; rd_tid = 9'h0; ext_data = 64'h0;
   endtask

   task automatic drive(input vec_t v);
      wr_valid = v.wv; wr_addr = v.wa; wr_data = v.wd;
      rd_valid = v.rv; rd_addr = v.ra; rd_tid = v.tid; ext_data = v.ext;
   endtask

   initial begin
      // ------------------------------------------------------ build table
      vecs.push_back(w(16'h0020, 64'hA, 4'd1, 1'b0, 1'b0));
      vecs.push_back(w(16'h0020, 64'hB, 4'd2, 1'b0, 1'b0));
      vecs.push_back(w(16'h0020, 64'hC, 4'd3, 1'b0, 1'b0));
      vecs.push_back(r(16'h0020, 9'd1, 64'h0, 64'hA, 4'd2, 1'b0, 1'b0));
      vecs.push_back(r(16'h0020, 9'd2, 64'h0, 64'hB, 4'd1, 1'b0, 1'b0));
      vecs.push_back(r(16'h0020, 9'd3, 64'h0, 64'hC, 4'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 9'h0, 64'h0, 64'h0, 4'd0, 1'b0, 1'b0));
      // Unowned write address: ignored.
      vecs.push_back(w(16'h0028, 64'h5, 4'd0, 1'b0, 1'b0));
      // Fill with 0x10..0x17, ninth write 0x18 is dropped.
      for (int i = 0; i < 8; i++)
         vecs.push_back(w(16'h0020, 64'h10 + 64'(i), 4'(i + 1), 1'b0, 1'b0));
      vecs.push_back(w(16'h0020, 64'h18, 4'd8, 1'b1, 1'b0));
      vecs.push_back(r(16'h0022, 9'd4, 64'h0, 64'h0001_0000_0008_0006, 4'd8, 1'b1, 1'b0));
      vecs.push_back(w(16'h0024, 64'h1, 4'd8, 1'b0, 1'b0));
      vecs.push_back(r(16'h0022, 9'd5, 64'h0, 64'h0000_0000_0008_0002, 4'd8, 1'b0, 1'b0));
      // Full + simultaneous push/pop: oldest returned, 0x99 accepted.
      vecs.push_back(wr(16'h0020, 64'h99, 16'h0020, 9'd6, 64'h10, 4'd8, 1'b0, 1'b0));
      for (int i = 0; i < 7; i++)
         vecs.push_back(r(16'h0020, 9'(7 + i), 64'h0, 64'h11 + 64'(i), 4'(7 - i), 1'b0, 1'b0));
      vecs.push_back(r(16'h0020, 9'd14, 64'h0, 64'h99, 4'd0, 1'b0, 1'b0));
      // Underflow, then clear.
      vecs.push_back(r(16'h0020, 9'd8, 64'h0, 64'h0, 4'd0, 1'b0, 1'b1));
      vecs.push_back(w(16'h0024, 64'h1, 4'd0, 1'b0, 1'b0));
      // Empty + simultaneous push/pop: response 0, push lands.
      vecs.push_back(wr(16'h0020, 64'h55, 16'h0020, 9'd9, 64'h0, 4'd1, 1'b0, 1'b1));
      vecs.push_back(r(16'h0020, 9'd10, 64'h0, 64'h55, 4'd0, 1'b0, 1'b1));
      vecs.push_back(w(16'h0024, 64'h1, 4'd0, 1'b0, 1'b0));
      // Flush + simultaneous pop: old head returned, queue ends empty.
      vecs.push_back(w(16'h0020, 64'h21, 4'd1, 1'b0, 1'b0));
      vecs.push_back(w(16'h0020, 64'h22, 4'd2, 1'b0, 1'b0));
      vecs.push_back(wr(16'h0024, 64'h2, 16'h0020, 9'd11, 64'h21, 4'd0, 1'b0, 1'b0));
      vecs.push_back(r(16'h0020, 9'd12, 64'h0, 64'h0, 4'd0, 1'b0, 1'b1));
      // Both clear bits in one write.
      vecs.push_back(w(16'h0020, 64'h31, 4'd1, 1'b0, 1'b1));
      vecs.push_back(w(16'h0024, 64'h3, 4'd0, 1'b0, 1'b0));
      // Unowned read address returns ext_data.
      vecs.push_back(r(16'h0000, 9'h1FF, 64'h1000_0000_0000_0000,
                       64'h1000_0000_0000_0000, 4'd0, 1'b0, 1'b0));
      // Peek register.
      vecs.push_back(w(16'h0020, 64'h7, 4'd1, 1'b0, 1'b0));
      vecs.push_back(r(16'h0026, 9'h20, 64'hDEAD, PEEK ? 64'h7 : 64'hDEAD, 4'd1, 1'b0, 1'b0));
      vecs.push_back(r(16'h0026, 9'h21, 64'hDEAD, PEEK ? 64'h7 : 64'hDEAD, 4'd1, 1'b0, 1'b0));
      vecs.push_back(r(16'h0020, 9'h22, 64'h0, 64'h7, 4'd0, 1'b0, 1'b0));
      vecs.push_back(r(16'h0026, 9'h23, 64'hBEEF, PEEK ? 64'h0 : 64'hBEEF, 4'd0, 1'b0, 1'b0));
      // Status shows pre-update state despite a same-cycle push.
      vecs.push_back(wr(16'h0020, 64'h66, 16'h0022, 9'h24, 64'h0000_0000_0000_0001,
                        4'd1, 1'b0, 1'b0));
      vecs.push_back(r(16'h0020, 9'h25, 64'h0, 64'h66, 4'd0, 1'b0, 1'b0));

      // ------------------------------------------------------------ reset
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset rsp_valid", rsp_valid, 1'b0);
      check("reset rsp_tid", rsp_tid, 9'h0);
      check("reset rsp_data", rsp_data, 64'h0);
      check("reset count", count, 4'd0);
      check("reset empty", empty, 1'b1);
      check("reset full", full, 1'b0);
      check("reset ovf", ovf, 1'b0);
      check("reset udf", udf, 1'b0);

      // ------------------------------------------------------- table run
      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         idle_inputs();
         check($sformatf("v%0d rsp_valid", i), rsp_valid, vecs[i].ev);
         if (vecs[i].ev) begin
            check($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].ed);
            check($sformatf("v%0d rsp_tid", i), rsp_tid, vecs[i].tid);
         end
         check($sformatf("v%0d count", i), count, vecs[i].ecnt);
         check($sformatf("v%0d full", i), full, vecs[i].ecnt == 4'd8);
         check($sformatf("v%0d empty", i), empty, vecs[i].ecnt == 4'd0);
         check($sformatf("v%0d ovf", i), ovf, vecs[i].eovf);
         check($sformatf("v%0d udf", i), udf, vecs[i].eudf);
      end

      // ---------------------------------------------- mid-stream reset
      wr_valid = 1'b1; wr_addr = 16'h0020; wr_data = 64'h41;
      @(posedge clk); #1;
      wr_data = 64'h42;
      @(posedge clk); #1;
      idle_inputs();
      check("pre-reset count", count, 4'd2);
      rst = 1'b1;
      rd_valid = 1'b1; rd_addr = 16'h0020; rd_tid = 9'h33;
      @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();
      check("rst-read rsp_valid", rsp_valid, 1'b0);
      check("rst-read count", count, 4'd0);
      check("rst-read empty", empty, 1'b1);
      @(posedge clk); #1;
      check("post-rst idle rsp_valid", rsp_valid, 1'b0);
      rd_valid = 1'b1; rd_addr = 16'h0020; rd_tid = 9'h34;
      @(posedge clk); #1;
      idle_inputs();
      check("post-rst read rsp_valid", rsp_valid, 1'b1);
      check("post-rst read rsp_data", rsp_data, 64'h0);
      check("post-rst read rsp_tid", rsp_tid, 9'h34);
      check("post-rst read udf", udf, 1'b1);
      @(posedge clk); #1;
      check("pulse cleared", rsp_valid, 1'b0);
      check("tid held", rsp_tid, 9'h34);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
